// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared constants for the sequential signed divider: FSM
//               state encoding, default operand width and the Z register
//               bus-multiplexer select codes used by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  // Default operand/result width; the iteration count equals this value.
  localparam int c_DEFAULT_WIDTH = 32;

  // Divider FSM state encoding.
  typedef logic [1:0] divState_t;
  localparam divState_t c_IDLE = 2'd0;
  localparam divState_t c_CALC = 2'd1;
  localparam divState_t c_FIX  = 2'd2;
  localparam divState_t c_DONE = 2'd3;

  // Bus-multiplexer select codes for the Z register pair.
  localparam logic [4:0] c_ZSEL_HIGH = 5'd18;  // remainder
  localparam logic [4:0] c_ZSEL_LOW  = 5'd19;  // quotient

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Request/result bundle between the control unit (master) and
//               the sequential divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] z_low;
  logic [WIDTH-1:0] z_high;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Control-unit side: issues requests, observes results.
  modport master (
    output start, dividend, divisor,
    input  z_low, z_high, busy, done, div_by_zero
  );

  // Divider side: accepts requests, produces results.
  modport slave (
    input  start, dividend, divisor,
    output z_low, z_high, busy, done, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational non-restoring division iteration on
//               magnitudes. A is a signed partial remainder one bit wider
//               than the operands; Q collects quotient bits from the right.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_aNext,
  output logic [WIDTH-1:0] o_qNext
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_mExt;

  // Shifting {A,Q} left drops A's sign bit; that is safe because |A| < M and
  // M never exceeds 2^(WIDTH-1), so 2A+q always fits in WIDTH+1 bits.
  assign w_shifted = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_mExt    = {1'b0, i_m};

  // Subtract when the pre-shift remainder is non-negative, otherwise add back.
  assign o_aNext = i_a[WIDTH] ? (w_shifted + w_mExt) : (w_shifted - w_mExt);

  // New quotient bit is set when the updated remainder is non-negative.
  assign o_qNext = {i_q[WIDTH-2:0], ~o_aNext[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed divider feeding the Z register pair.
//               Non-restoring division on operand magnitudes (one bit per
//               cycle), then a fix-up cycle that restores the remainder and
//               applies truncating-division signs. Quotient -> z_low,
//               remainder -> z_high.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic         clock,
  input  logic         clear,
  seq_divider_if.slave bus
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

  divState_t        r_state;
  divState_t        w_stateNext;

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_signQ;
  logic             r_signR;
  logic [c_CNT_W-1:0] r_count;

  logic [WIDTH-1:0] r_zLow;
  logic [WIDTH-1:0] r_zHigh;
  logic             r_divByZero;

  logic             w_busy;
  logic             w_done;
  logic             w_divisorZero;
  logic [WIDTH-1:0] w_dividendMag;
  logic [WIDTH-1:0] w_divisorMag;
  logic [WIDTH:0]   w_aStep;
  logic [WIDTH-1:0] w_qStep;
  logic [WIDTH:0]   w_aFix;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) read as unsigned.
  assign w_divisorZero = (bus.divisor == '0);
  assign w_dividendMag = bus.dividend[WIDTH-1] ? (-bus.dividend) : bus.dividend;
  assign w_divisorMag  = bus.divisor[WIDTH-1]  ? (-bus.divisor)  : bus.divisor;

  // A negative final partial remainder needs one add-back of M.
  assign w_aFix = r_a[WIDTH] ? (r_a + {1'b0, r_m}) : r_a;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a     (r_a),
    .i_q     (r_q),
    .i_m     (r_m),
    .o_aNext (w_aStep),
    .o_qNext (w_qStep)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; start is only looked at while idle, so it never queues.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.start) begin
          w_stateNext = w_divisorZero ? c_DONE : c_CALC;
        end
      end
      c_CALC: begin
        if (r_count == c_LAST_STEP) begin
          w_stateNext = c_FIX;
        end
      end
      c_FIX:   w_stateNext = c_DONE;
      c_DONE:  w_stateNext = c_IDLE;
      default: w_stateNext = c_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_CALC:  w_busy = 1'b1;
      c_FIX:   w_busy = 1'b1;
      c_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, one iteration per CALC cycle, result write-back.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_signQ     <= 1'b0;
      r_signR     <= 1'b0;
      r_count     <= '0;
      r_zLow      <= '0;
      r_zHigh     <= '0;
      r_divByZero <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            if (w_divisorZero) begin
              // Divide by zero short-circuits straight to DONE.
              r_zLow      <= '1;
              r_zHigh     <= bus.dividend;
              r_divByZero <= 1'b1;
            end else begin
              r_a         <= '0;
              r_q         <= w_dividendMag;
              r_m         <= w_divisorMag;
              r_signQ     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_signR     <= bus.dividend[WIDTH-1];
              r_count     <= '0;
              r_divByZero <= 1'b0;
            end
          end
        end
        c_CALC: begin
          r_a     <= w_aStep;
          r_q     <= w_qStep;
          r_count <= r_count + 1'b1;
        end
        c_FIX: begin
          // Quotient rounds toward zero; remainder carries the dividend's sign.
          r_a     <= w_aFix;
          r_zLow  <= r_signQ ? (-r_q) : r_q;
          r_zHigh <= r_signR ? (-w_aFix[WIDTH-1:0]) : w_aFix[WIDTH-1:0];
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

  assign bus.z_low       = r_zLow;
  assign bus.z_high      = r_zHigh;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_divByZero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed bench for seq_divider: a vector table of signed
//               divisions with hand-computed results, plus sequences for an
//               ignored mid-operation start and a mid-operation clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clock (clk),
    .clear (rst),
    .bus   (dif)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] expLow;
    logic [31:0] expHigh;
    logic        expDbz;
    int          expLat;
  } vec_t;

  localparam int c_NVEC = 16;
  vec_t vecs [c_NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one request; lat = number of edges after the start edge until done
  // is seen (0 = done in the cycle right after the start edge).
  task automatic runOp(input logic [31:0] dvd, input logic [31:0] dvs,
                       output int lat, output logic busyOk);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    lat    = 0;
    busyOk = 1'b1;
    while (dif.done !== 1'b1 && lat < 100) begin
      if (dif.busy !== 1'b1) busyOk = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (dif.busy !== 1'b0) busyOk = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        busyOk;
    int          doneCount;
    int          firstDone;

    vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{-32'sd100,    32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
    vecs[2]  = '{32'd100,      -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0, 33};
    vecs[3]  = '{-32'sd100,    -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0, 33};
    vecs[4]  = '{32'd55,       32'd0,          32'hFFFF_FFFF,  32'd55,         1'b1, 0};
    vecs[5]  = '{32'd9,        32'd3,          32'd3,          32'd0,          1'b0, 33};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[7]  = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF,  32'd0,          1'b0, 33};
    vecs[8]  = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[9]  = '{32'h8000_0000, 32'd1,         32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[10] = '{32'd7,        32'd100,        32'd0,          32'd7,          1'b0, 33};
    vecs[11] = '{-32'sd7,      32'd100,        32'd0,          32'hFFFF_FFF9,  1'b0, 33};
    vecs[12] = '{-32'sd5,      32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 0};
    vecs[13] = '{32'd1000,     32'd3,          32'd333,        32'd1,          1'b0, 33};
    vecs[14] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,          32'h7FFF_FFFF,  1'b0, 33};
    vecs[15] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 33};

    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset zLow",   dif.z_low,                 32'd0);
    check("reset zHigh",  dif.z_high,                32'd0);
    check("reset busy",   {31'd0, dif.busy},         32'd0);
    check("reset done",   {31'd0, dif.done},         32'd0);
    check("reset dbz",    {31'd0, dif.div_by_zero},  32'd0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < c_NVEC; i++) begin
      runOp(vecs[i].dvd, vecs[i].dvs, lat, busyOk);
      check($sformatf("v%0d zLow", i),    dif.z_low,                 vecs[i].expLow);
      check($sformatf("v%0d zHigh", i),   dif.z_high,                vecs[i].expHigh);
      check($sformatf("v%0d dbz", i),     {31'd0, dif.div_by_zero},  {31'd0, vecs[i].expDbz});
      check($sformatf("v%0d latency", i), lat,                       vecs[i].expLat);
      check($sformatf("v%0d busy", i),    {31'd0, busyOk},           32'd1);
      @(negedge clk);
      check($sformatf("v%0d donePulse", i), {31'd0, dif.done},       32'd0);
      check($sformatf("v%0d zLowHold", i),  dif.z_low,               vecs[i].expLow);
    end

    // Start while busy (edge 10) and while in DONE must both be ignored.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    @(negedge clk);
    doneCount = 0;
    firstDone = -1;
    for (int k = 0; k < 60; k++) begin
      if (dif.done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) firstDone = k;
      end
      dif.start    = (k == 9) || (dif.done === 1'b1);
      dif.dividend = dif.start ? 32'd8 : 32'd0;
      dif.divisor  = dif.start ? 32'd2 : 32'd0;
      @(negedge clk);
    end
    dif.start = 1'b0;
    check("ignore doneCount", doneCount,        32'd1);
    check("ignore latency",   firstDone,        32'd33);
    check("ignore zLow",      dif.z_low,        32'd333);
    check("ignore zHigh",     dif.z_high,       32'd1);
    check("ignore busyAfter", {31'd0, dif.busy}, 32'd0);

    // Clear in the middle of an operation aborts it without a done pulse.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("clear busy",  {31'd0, dif.busy},        32'd0);
    check("clear done",  {31'd0, dif.done},        32'd0);
    check("clear zLow",  dif.z_low,                32'd0);
    check("clear zHigh", dif.z_high,               32'd0);
    check("clear dbz",   {31'd0, dif.div_by_zero}, 32'd0);
    rst = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 50; k++) begin
      if (dif.done === 1'b1 || dif.busy === 1'b1) doneCount++;
      @(negedge clk);
    end
    check("clear noActivity", doneCount, 32'd0);
    runOp(32'd9, 32'd3, lat, busyOk);
    check("after clear zLow",    dif.z_low,  32'd3);
    check("after clear zHigh",   dif.z_high, 32'd0);
    check("after clear latency", lat,        32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
